mulu_x3y3_seq: RTL and testbench

- Pipelined 3-bit x 3-bit unsigned multiplier with a 6-bit product.
- Synchronous wrapper around an explicit partial-product adder array (AND-plane plus half/full-adder rows; no behavioural `*`).
- Leaf arithmetic block under the top-level multiplier harness; `rdy` indicates the pipeline holds valid results.

---
 rtl/mulu_x3y3_seq.sv | 151 +++++++++++++++
 tb/tb_mulu_x3y3_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mulu_x3y3_seq.sv
// mulu_x3y3_seq: two-stage pipelined 3x3 multiplier built from an explicit
// AND-plane and half/full-adder array.
// Stage 1 registers the operands and stage 2 registers the 6-bit product, so a
// result appears two rising edges after its operands are sampled.
// Optional build macro MULU_SIGN_EN: operands are 3-bit two's complement.
// Stage 1 then holds the operand magnitudes and the product sign. The s port
// carries the sign, which is forced to 0 for a zero product.
module mulu_x3y3_seq #(
    parameter int unsigned X_WIDTH = 3,
    parameter int unsigned Y_WIDTH = 3,
    parameter int unsigned P_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
    output logic [P_WIDTH-1:0] p,
    output logic               rdy
`ifdef MULU_SIGN_EN
    ,
    output logic               s
`endif
);

    // Half adder: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic a, input logic b);
        half_add = {a & b, a ^ b};
    endfunction

    // Full adder: returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        full_add = {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

`ifdef MULU_SIGN_EN
    // Two's-complement magnitude; -4 (100) maps to 4 (100), which still fits in 3 bits.
    function automatic logic [2:0] mag3(input logic [2:0] v);
        mag3 = v[2] ? (~v + 3'd1) : v;
    endfunction
`endif

    // Stage 1 state.
    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic               v1_q;
`ifdef MULU_SIGN_EN
    logic               sign_q, sign_d;
    logic               s_q, s_d;
`endif

    // Stage 2 state.
    logic [P_WIDTH-1:0] p_q;
    logic               rdy_q;

    // Array signals.
    logic [2:0][2:0]    pp;       // pp[i][j] = x_q[j] & y_q[i]
    logic [4:1]         row1;     // row0 + (row1 << 1); row1[4] is the carry-out
    logic [1:0]         ha_b1, fa_b2, ha_b3;
    logic [1:0]         fa_c2, fa_c3, fa_c4;
    logic [P_WIDTH-1:0] prod;

    // Stage 1 operand selection: raw operands, or magnitudes plus sign in signed mode.
    always_comb begin
`ifdef MULU_SIGN_EN
        x_d    = mag3(x);
        y_d    = mag3(y);
        sign_d = x[2] ^ y[2];
`else
        x_d    = x;
        y_d    = y;
`endif
    end

    // Stage 1 registers: operands and the fill-tracking valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            v1_q   <= 1'b0;
`ifdef MULU_SIGN_EN
            sign_q <= 1'b0;
`endif
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            v1_q   <= 1'b1;
`ifdef MULU_SIGN_EN
            sign_q <= sign_d;
`endif
        end
    end

    // Partial-product array: AND plane, half/full-adder row 1, full-adder ripple row 2.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                pp[i][j] = x_q[j] & y_q[i];
            end
        end

        // Row 1: pp[0] (weights 1..2) plus pp[1] (weights 1..3).
        ha_b1   = half_add(pp[0][1], pp[1][0]);
        fa_b2   = full_add(pp[0][2], pp[1][1], ha_b1[1]);
        ha_b3   = half_add(pp[1][2], fa_b2[1]);
        row1[1] = ha_b1[0];
        row1[2] = fa_b2[0];
        row1[3] = ha_b3[0];
        row1[4] = ha_b3[1];

        // Row 2: pp[2] (weights 2..4) rippled into the row-1 sum.
        fa_c2   = full_add(row1[2], pp[2][0], 1'b0);
        fa_c3   = full_add(row1[3], pp[2][1], fa_c2[1]);
        fa_c4   = full_add(row1[4], pp[2][2], fa_c3[1]);

        prod    = {fa_c4[1], fa_c4[0], fa_c3[0], fa_c2[0], row1[1], pp[0][0]};
    end

`ifdef MULU_SIGN_EN
    // A zero magnitude has no sign.
    always_comb begin
        s_d = sign_q & (prod != '0);
    end
`endif

    // Stage 2 registers: product and ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            rdy_q <= 1'b0;
`ifdef MULU_SIGN_EN
            s_q   <= 1'b0;
`endif
        end else begin
            p_q   <= prod;
            rdy_q <= v1_q;
`ifdef MULU_SIGN_EN
            s_q   <= s_d;
`endif
        end
    end

    // Output drive.
    always_comb begin
        p   = p_q;
        rdy = rdy_q;
`ifdef MULU_SIGN_EN
        s   = s_q;
`endif
    end

endmodule

// File: tb/tb_mulu_x3y3_seq.sv
// Self-checking bench for mulu_x3y3_seq. The reference model computes each
// product arithmetically from the driven operands. It expects that product on p
// two edges later, and expects p=0 and rdy=0 during the two-edge fill.
module tb_mulu_x3y3_seq;

    logic       clk;
    logic       rst_n;
    logic [2:0] x;
    logic [2:0] y;
    logic [5:0] p;
    logic       rdy;
`ifdef MULU_SIGN_EN
    logic       s;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int unsigned edges_since_reset = 0;
    logic [6:0]  exp_q[$];        // {sign, product} per sampled operand pair
    logic [5:0]  exp_p = '0;
    logic        exp_s = 1'b0;
    logic        exp_rdy = 1'b0;

    mulu_x3y3_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .p     (p),
        .rdy   (rdy)
`ifdef MULU_SIGN_EN
        ,
        .s     (s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is bounded by the stimulus, so this only fires on a hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {sign, product} for one operand pair.
    function automatic logic [6:0] ref_prod(input logic [2:0] a, input logic [2:0] b);
        int ai, bi, pr;
`ifdef MULU_SIGN_EN
        ai = a[2] ? int'(a) - 8 : int'(a);
        bi = b[2] ? int'(b) - 8 : int'(b);
        pr = ai * bi;
        if (pr < 0) return {1'b1, 6'(-pr)};
        return {1'b0, 6'(pr)};
`else
        ai = int'(a);
        bi = int'(b);
        pr = ai * bi;
        return {1'b0, 6'(pr)};
`endif
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".rdy"}, int'(rdy), int'(exp_rdy));
        check_eq({tag, ".p"}, int'(p), int'(exp_p));
`ifdef MULU_SIGN_EN
        check_eq({tag, ".s"}, int'(s), int'(exp_s));
`endif
    endtask

    // One cycle, called at a negedge: drive operands, advance the model on the
    // rising edge, then check the outputs at the next negedge.
    task automatic step(input logic [2:0] a, input logic [2:0] b, input string tag);
        logic [6:0] e;
        x = a;
        y = b;
        @(posedge clk);
        edges_since_reset++;
        exp_q.push_back(ref_prod(a, b));
        if (edges_since_reset >= 2) begin
            e       = exp_q.pop_front();
            exp_p   = e[5:0];
            exp_s   = e[6];
            exp_rdy = 1'b1;
        end else begin
            exp_p   = '0;
            exp_s   = 1'b0;
            exp_rdy = 1'b0;
        end
        // Inputs wiggling between edges must not matter.
        #2;
        x = 3'($urandom);
        y = 3'($urandom);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic model_reset();
        edges_since_reset = 0;
        exp_q.delete();
        exp_p   = '0;
        exp_s   = 1'b0;
        exp_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        x     = 3'd7;
        y     = 3'd7;
        model_reset();

        // Reset held with the clock running.
        repeat (3) @(negedge clk);
        check_outputs("reset_hold");

        // Release at a negedge; edge 1 keeps rdy low, edge 2 yields 7*7.
        rst_n = 1'b1;
        step(3'd7, 3'd7, "fill_e1");
        step(3'd7, 3'd7, "fill_e2");

`ifndef MULU_SIGN_EN
        check_eq("fill_49", int'(p), 49);

        // Directed pairs, each separated by idle cycles so the two-edge latency is exposed.
        step(3'd5, 3'd3, "dir_5x3_a");
        step(3'd0, 3'd0, "dir_5x3_b");
        check_eq("dir_5x3", int'(p), 15);
        step(3'd7, 3'd1, "dir_7x1_a");
        step(3'd0, 3'd0, "dir_7x1_b");
        check_eq("dir_7x1", int'(p), 7);
        step(3'd0, 3'd6, "dir_0x6_a");
        step(3'd0, 3'd0, "dir_0x6_b");
        check_eq("dir_0x6", int'(p), 0);
        step(3'd4, 3'd4, "dir_4x4_a");
        step(3'd0, 3'd0, "dir_4x4_b");
        check_eq("dir_4x4", int'(p), 16);

        // Back-to-back stream: 6, 42, 1 on consecutive cycles.
        step(3'd3, 3'd2, "b2b_0");
        step(3'd6, 3'd7, "b2b_1");
        check_eq("b2b_6", int'(p), 6);
        step(3'd1, 3'd1, "b2b_2");
        check_eq("b2b_42", int'(p), 42);
        step(3'd0, 3'd0, "b2b_3");
        check_eq("b2b_1", int'(p), 1);
`else
        check_eq("fill_1", int'(p), 1);

        step(3'b111, 3'b011, "sgn_a_in");
        step(3'b000, 3'b000, "sgn_a_out");
        check_eq("sgn_m1x3_p", int'(p), 3);
        check_eq("sgn_m1x3_s", int'(s), 1);
        step(3'b100, 3'b100, "sgn_b_in");
        step(3'b000, 3'b000, "sgn_b_out");
        check_eq("sgn_m4xm4_p", int'(p), 16);
        check_eq("sgn_m4xm4_s", int'(s), 0);
        step(3'b000, 3'b100, "sgn_c_in");
        step(3'b000, 3'b000, "sgn_c_out");
        check_eq("sgn_0xm4_p", int'(p), 0);
        check_eq("sgn_0xm4_s", int'(s), 0);
        step(3'b010, 3'b101, "sgn_d_in");
        step(3'b000, 3'b000, "sgn_d_out");
        check_eq("sgn_2xm3_p", int'(p), 6);
        check_eq("sgn_2xm3_s", int'(s), 1);
`endif

        // Exhaustive stream of all 64 pairs, then two flush cycles.
        for (int i = 0; i < 64; i++) begin
            step(3'(i >> 3), 3'(i), "exh");
        end
        step(3'd0, 3'd0, "exh_flush0");
        step(3'd0, 3'd0, "exh_flush1");

        // Random stream.
        for (int i = 0; i < 40; i++) begin
            step(3'($urandom), 3'($urandom), "rnd");
        end

        // Mid-stream asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst_now");
        @(negedge clk);
        check_outputs("midrst_hold");
        rst_n = 1'b1;
        step(3'd6, 3'd5, "midrst_e1");
        step(3'd2, 3'd3, "midrst_e2");
        for (int i = 0; i < 10; i++) begin
            step(3'($urandom), 3'($urandom), "post_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
